// File: rtl/rv32_pkg.sv
// Shared constants and types for the RV32 instruction fetch front end.
package rv32_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a response that arrived while decode was stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d   = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= vld_d;
  end

  // Payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
  end

  assign valid = vld_q;
  assign instr = instr_q;
  assign pc    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request, D pipeline register,
// skid entry for stalled decode, and redirect with squash of in-flight responses.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic         squash_q, squash_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcd_q, pcd_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_instr, skid_pc;
  logic         d_free, req_fire;

  fetch_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .clear    (skid_clear),
    .instr_in (imem_rsp_data),
    .pc_in    (out_pc_q),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // Gated by reset so no request is visible while reset is held.
  assign imem_req_valid = (state_q == S_REQ) && !reset;
  assign imem_addr      = pcf_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign d_free         = !valid_q || !StallD;

  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    out_pc_d   = out_pc_q;
    squash_d   = squash_q;
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    pcp4_d     = pcp4_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    // Decode consumed the live instruction; overridden below if a new one lands.
    if (valid_q && !StallD) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    if (PCSrcE) begin
      pcf_d      = PCTargetE & ~32'h3;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      skid_clear = 1'b1;
      if (req_fire || (state_q == S_WAIT && !imem_rsp_valid)) begin
        state_d  = S_WAIT;
        squash_d = 1'b1;
      end else begin
        state_d  = S_REQ;
        squash_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) begin
            out_pc_d = pcf_q;
            pcf_d    = pcf_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = S_REQ;
            if (squash_q) begin
              squash_d = 1'b0;
            end else if (d_free) begin
              instr_d = imem_rsp_data;
              pcd_d   = out_pc_q;
              pcp4_d  = out_pc_q + 32'd4;
              valid_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!StallD && skid_valid) begin
            instr_d    = skid_instr;
            pcd_d      = skid_pc;
            pcp4_d     = skid_pc + 32'd4;
            valid_d    = 1'b1;
            skid_clear = 1'b1;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_REQ;
      pcf_q    <= RESET_PC;
      out_pc_q <= 32'h0;
      squash_q <= 1'b0;
      instr_q  <= NOP_INSTR;
      pcd_q    <= 32'h0;
      pcp4_q   <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      out_pc_q <= out_pc_d;
      squash_q <= squash_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      pcp4_q   <= pcp4_d;
      valid_q  <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked against
// a transaction-level model built from request/skid queues.
module tb_fetch_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .StallD         (StallD),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit sq; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } held_t;

  req_t        outq[$];
  held_t       skq[$];
  logic [31:0] m_pcf, m_instr, m_pcd;
  bit          m_dv;

  bit          auto_mem;
  bit          mem_busy;
  int          mem_lat, lat_max;
  logic [31:0] mem_addr;

  bit          last_fire;
  logic [31:0] last_addr;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_req();
    return !reset && outq.size() == 0 && skq.size() == 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    outq.delete();
    skq.delete();
    m_pcf    = 32'h0;
    m_dv     = 1'b0;
    m_instr  = NOP_INSTR;
    m_pcd    = 32'h0;
    mem_busy = 1'b0;
  endtask

  task automatic check_model();
    chk("req_valid", 32'(imem_req_valid), 32'(m_req()));
    chk("imem_addr", imem_addr, m_pcf);
    chk("ValidD", 32'(ValidD), 32'(m_dv));
    chk("InstrD", InstrD, m_instr);
    if (m_dv) begin
      chk("PCD", PCD, m_pcd);
      chk("PCPlus4D", PCPlus4D, m_pcd + 32'd4);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_ValidD"}, 32'(ValidD), 32'h0);
    chk({tag, "_InstrD"}, InstrD, 32'h0000_0013);
    chk({tag, "_PCD"}, PCD, 32'h0);
    chk({tag, "_PCPlus4D"}, PCPlus4D, 32'h0);
  endtask

  // One clock: sample inputs, advance the model across the edge, compare after.
  task automatic cycle();
    bit          fire, rsp, stall, redir, dfree, loaded;
    logic [31:0] req_pc, rdata, tgt;
    req_t        e;
    held_t       s;
    if (auto_mem) begin
      imem_rsp_valid = mem_busy && mem_lat == 0;
      imem_rsp_data  = mem_busy ? mem_word(mem_addr) : 32'h0;
    end
    fire      = m_req() && imem_req_ready;
    req_pc    = m_pcf;
    rsp       = imem_rsp_valid;
    rdata     = imem_rsp_data;
    stall     = StallD;
    redir     = PCSrcE;
    tgt       = PCTargetE;
    last_fire = imem_req_valid && imem_req_ready;
    last_addr = imem_addr;
    @(posedge clk);
    if (redir) begin
      if (rsp && outq.size() > 0) void'(outq.pop_front());
      if (fire) outq.push_back('{req_pc, 1'b0});
      foreach (outq[i]) outq[i].sq = 1'b1;
      skq.delete();
      m_dv    = 1'b0;
      m_instr = NOP_INSTR;
      m_pcf   = tgt & ~32'h3;
    end else begin
      dfree  = !m_dv || !stall;
      loaded = 1'b0;
      if (skq.size() > 0 && !stall) begin
        s       = skq.pop_front();
        m_dv    = 1'b1;
        m_instr = s.instr;
        m_pcd   = s.pc;
        loaded  = 1'b1;
      end
      if (rsp && outq.size() > 0) begin
        e = outq.pop_front();
        if (!e.sq) begin
          if (dfree) begin
            m_dv    = 1'b1;
            m_instr = rdata;
            m_pcd   = e.pc;
            loaded  = 1'b1;
          end else begin
            skq.push_back('{rdata, e.pc});
          end
        end
      end
      if (fire) begin
        outq.push_back('{req_pc, 1'b0});
        m_pcf = req_pc + 32'd4;
      end
      if (!loaded && m_dv && !stall) begin
        m_dv    = 1'b0;
        m_instr = NOP_INSTR;
      end
    end
    if (auto_mem) begin
      if (rsp) mem_busy = 1'b0;
      else if (mem_busy && mem_lat > 0) mem_lat--;
      if (fire) begin
        mem_busy = 1'b1;
        mem_addr = req_pc;
        mem_lat  = $urandom_range(lat_max, 0);
      end
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    PCSrcE         = 1'b0;
    PCTargetE      = 32'h0;
    StallD         = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'h1);
    chk("first_req_addr", imem_addr, 32'h0);
  endtask

  // Leaves D holding 0x00500093 under stall with 0x00208133 parked in the skid.
  task automatic reach_hold();
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    cycle();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    cycle();
    chk("hold_d_loaded", InstrD, 32'h0050_0093);
    imem_rsp_valid = 1'b0;
    StallD         = 1'b1;
    cycle();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0020_8133;
    cycle();
    imem_rsp_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] addrs[$];
    logic [31:0] pcds[$];
    logic [31:0] p4s[$];
    logic [31:0] got;

    auto_mem = 1'b0;
    lat_max  = 0;

    // Back-to-back fetch with single-cycle memory.
    do_reset();
    auto_mem       = 1'b1;
    lat_max        = 0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_fire) addrs.push_back(last_addr);
      if (ValidD) begin
        pcds.push_back(PCD);
        p4s.push_back(PCPlus4D);
      end
    end
    chk("t1_nreq", 32'(addrs.size()), 32'd3);
    chk("t1_nvalid", 32'(pcds.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (i < addrs.size()) ? addrs[i] : 32'hxxxx_xxxx;
      chk($sformatf("t1_addr%0d", i), got, 32'(i * 4));
      got = (i < pcds.size()) ? pcds[i] : 32'hxxxx_xxxx;
      chk($sformatf("t1_pcd%0d", i), got, 32'(i * 4));
      got = (i < p4s.size()) ? p4s[i] : 32'hxxxx_xxxx;
      chk($sformatf("t1_p4_%0d", i), got, 32'(i * 4 + 4));
    end
    auto_mem = 1'b0;

    // Stall while a response arrives, then release.
    do_reset();
    reach_hold();
    chk("t2_held_instr", InstrD, 32'h0050_0093);
    chk("t2_held_valid", 32'(ValidD), 32'h1);
    chk("t2_no_req", 32'(imem_req_valid), 32'h0);
    cycle();
    chk("t2_still_no_req", 32'(imem_req_valid), 32'h0);
    chk("t2_still_held", InstrD, 32'h0050_0093);
    StallD = 1'b0;
    cycle();
    chk("t2_released_instr", InstrD, 32'h0020_8133);
    chk("t2_released_pcd", PCD, 32'h4);
    chk("t2_next_addr", imem_addr, 32'h8);

    // Redirect while waiting; pending response must be dropped.
    do_reset();
    imem_req_ready = 1'b1;
    cycle();
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0103;
    cycle();
    PCSrcE = 1'b0;
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_valid0", 32'(ValidD), 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    cycle();
    chk("t3_dropped_valid", 32'(ValidD), 32'h0);
    chk("t3_dropped_instr", InstrD, 32'h0000_0013);
    chk("t3_refetch", 32'(imem_req_valid), 32'h1);
    imem_rsp_valid = 1'b0;
    cycle();
    chk("t3_wait_valid", 32'(ValidD), 32'h0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0093;
    cycle();
    imem_rsp_valid = 1'b0;
    chk("t3_target_instr", InstrD, 32'h0010_0093);
    chk("t3_target_pcd", PCD, 32'h100);

    // Redirect under stall with the skid full.
    do_reset();
    reach_hold();
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0200;
    cycle();
    PCSrcE = 1'b0;
    chk("t4_valid", 32'(ValidD), 32'h0);
    chk("t4_instr", InstrD, 32'h0000_0013);
    chk("t4_req", 32'(imem_req_valid), 32'h1);
    chk("t4_addr", imem_addr, 32'h200);
    cycle();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0AB0_0513;
    cycle();
    imem_rsp_valid = 1'b0;
    chk("t4_resume_instr", InstrD, 32'h0AB0_0513);
    chk("t4_resume_pcd", PCD, 32'h200);
    StallD = 1'b0;

    // Memory back-pressure: request and address stay put.
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("t5_valid%0d", i), 32'(imem_req_valid), 32'h1);
      chk($sformatf("t5_addr%0d", i), imem_addr, 32'h0);
    end
    imem_req_ready = 1'b1;
    cycle();
    chk("t5_accepted", imem_addr, 32'h4);

    // Reset arriving mid-wait; the late response must be ignored.
    do_reset();
    imem_req_ready = 1'b1;
    cycle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("t6a");
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0BAD;
    @(posedge clk);
    #1;
    check_reset_outputs("t6b");
    reset = 1'b0;
    #1;
    chk("t6_refetch_valid", 32'(imem_req_valid), 32'h1);
    chk("t6_refetch_addr", imem_addr, 32'h0);
    cycle();
    chk("t6_ignored", 32'(ValidD), 32'h0);
    imem_rsp_valid = 1'b0;
    cycle();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0030_0193;
    cycle();
    imem_rsp_valid = 1'b0;
    chk("t6_instr", InstrD, 32'h0030_0193);
    chk("t6_pcd", PCD, 32'h0);

    // Random traffic against the model.
    do_reset();
    auto_mem = 1'b1;
    lat_max  = 2;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      StallD         = ($urandom_range(2, 0) == 0);
      PCSrcE         = ($urandom_range(15, 0) == 0);
      PCTargetE      = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  input  1  instruction memory accepts the request.
REQ-006 SHALL have port imem_addr  output  32  fetch address (PCF).
REQ-007 SHALL have port imem_rsp_valid  input  1  instruction data valid.
REQ-008 SHALL have port imem_rsp_data  input  32  fetched instruction.
REQ-009 SHALL have port PCSrcE  input  1  redirect (taken branch or jal) from execute.
REQ-010 SHALL have port PCTargetE  input  32  redirect target.
REQ-011 SHALL have port StallD  input  1  decode cannot accept; hold the D register.
REQ-012 SHALL have port InstrD  output  32  instruction to decode; InstrD[6:0] drives the main decoder op.
REQ-013 SHALL have port PCD  output  32  PC of InstrD.
REQ-014 SHALL have port PCPlus4D  output  32  PCD+4.
REQ-015 SHALL have port ValidD  output  1  InstrD holds a live instruction.

Function
REQ-016 SHALL keep at most one memory request outstanding, tracked by FSM states S_REQ, S_WAIT and S_HOLD.
REQ-017 In S_REQ, SHALL drive imem_req_valid=1 and imem_addr=PCF; on imem_req_ready, SHALL latch PCF as the outstanding PC, set PCF<=PCF+4 (mod 2^32, wraps at 0xFFFF_FFFC), and go to S_WAIT.
REQ-018 In S_WAIT, SHALL drive imem_req_valid=0; on imem_rsp_valid, if the D register is free (ValidD=0 or StallD=0), SHALL load InstrD/PCD/PCPlus4D with ValidD=1 and go to S_REQ; otherwise SHALL capture the response in the skid entry and go to S_HOLD.
REQ-019 In S_HOLD, SHALL drive imem_req_valid=0; when StallD=0, SHALL move the skid entry into D and go to S_REQ.
REQ-020 When ValidD=1, StallD=0 and no new instruction is loaded, SHALL clear ValidD to 0 and set InstrD to 32'h0000_0013 (NOP).
REQ-021 While StallD=1 and ValidD=1, SHALL hold InstrD/PCD/PCPlus4D/ValidD unchanged.
REQ-022 PCSrcE=1 SHALL take priority over StallD and all other events: PCF<=PCTargetE with bits [1:0] forced to 00, ValidD<=0, InstrD<=NOP, skid entry cleared, next state S_REQ (or S_WAIT with squash set if a request is outstanding).
REQ-023 A request outstanding at redirect, including one accepted in the same cycle as PCSrcE, SHALL be marked squashed and its response SHALL be discarded without touching D.
REQ-024 imem_addr SHALL change while imem_req_valid=1 and imem_req_ready=0 only because of a redirect.
REQ-025 Best-case throughput SHALL be one instruction per two cycles when memory responds the cycle after acceptance (request cycle + response cycle).

Reset
REQ-026 While reset=1, SHALL force: state=S_REQ, PCF=RESET_PC, imem_req_valid=0, ValidD=0, InstrD=32'h0000_0013, PCD=0, PCPlus4D=0, squash=0, and skid empty.
REQ-027 The first request SHALL be issued in the first clock cycle after reset deasserts; responses in flight at reset SHALL be ignored.

Structure
REQ-028 Package rv32_pkg SHALL hold the NOP encoding constant, the fetch FSM state enum, and the RESET_PC default.
REQ-029 The skid entry SHALL be the sub-module fetch_skid, a one-entry instruction/PC holding register with load/clear/valid.

Verification
REQ-030 Bench SHALL cover: reset release with RESET_PC=0, ready=1, 1-cycle memory -> imem_addr 0x0,0x4,0x8; ValidD pulses with PCD 0x0,0x4,0x8 and PCPlus4D 0x4,0x8,0xC.
REQ-031 Bench SHALL cover: StallD=1 while InstrD=0x00500093 and a response 0x00208133 arrives -> D held; no new request; after StallD=0, InstrD=0x00208133 one cycle later.
REQ-032 Bench SHALL cover: PCSrcE=1, PCTargetE=0x0000_0103 while in S_WAIT -> next imem_addr=0x100; the pending response is dropped; ValidD=0 until the 0x100 response.
REQ-033 Bench SHALL cover: PCSrcE=1 with StallD=1 and skid full -> D and skid cleared; fetch resumes at the target.
REQ-034 Bench SHALL cover: imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr stable throughout.
REQ-035 Bench SHALL cover: reset asserted mid-S_WAIT, then a response arrives -> response ignored; all outputs at their reset values; refetch from RESET_PC.
